// File: rtl/dmem_dual_lane_arbiter.sv
// Data memory arbiter for the two issue lanes of the dual-issue pipe.
// Lane 0 (older) wins conflicts; lane 1 is buffered and replayed next cycle.
module dmem_dual_lane_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l0_req,
  input  logic              l0_we,
  input  logic [ADDR_W-1:0] l0_addr,
  input  logic [DATA_W-1:0] l0_wdata,
  input  logic              l1_req,
  input  logic              l1_we,
  input  logic [ADDR_W-1:0] l1_addr,
  input  logic [DATA_W-1:0] l1_wdata,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              l0_rvalid,
  output logic              l1_rvalid,
  output logic [DATA_W-1:0] l0_rdata,
  output logic [DATA_W-1:0] l1_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t            st;
  state_t            st_nx;
  logic              hb_we;
  logic [ADDR_W-1:0] hb_addr;
  logic [DATA_W-1:0] hb_wdata;
  logic              rd_pend;
  logic              rd_tag;
  logic              iss_tag;
  logic              cap;

  // Next state, memory port mux and lane-1 capture strobe.
  always_comb begin
    st_nx     = st;
    stall     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    iss_tag   = 1'b0;
    cap       = 1'b0;
    if (reset) begin
      unique case (st)
        RUN: begin
          if (l0_req) begin
            mem_en    = 1'b1;
            mem_we    = l0_we;
            mem_addr  = l0_addr;
            mem_wdata = l0_wdata;
            if (l1_req) begin
              stall = 1'b1;
              cap   = 1'b1;
              st_nx = HOLD;
            end
          end else if (l1_req) begin
            mem_en    = 1'b1;
            mem_we    = l1_we;
            mem_addr  = l1_addr;
            mem_wdata = l1_wdata;
            iss_tag   = 1'b1;
          end
        end
        HOLD: begin
          mem_en    = 1'b1;
          mem_we    = hb_we;
          mem_addr  = hb_addr;
          mem_wdata = hb_wdata;
          iss_tag   = 1'b1;
          st_nx     = RUN;
        end
        default: st_nx = RUN;
      endcase
    end
  end

  // State, hold buffer, read-return tracking and conflict counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st           <= RUN;
      hb_we        <= 1'b0;
      hb_addr      <= '0;
      hb_wdata     <= '0;
      rd_pend      <= 1'b0;
      rd_tag       <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      st      <= st_nx;
      rd_pend <= mem_en & ~mem_we;
      rd_tag  <= iss_tag;
      if (cap) begin
        hb_we    <= l1_we;
        hb_addr  <= l1_addr;
        hb_wdata <= l1_wdata;
        if (conflict_cnt != '1)
          conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign l0_rvalid = rd_pend & ~rd_tag;
  assign l1_rvalid = rd_pend & rd_tag;
  assign l0_rdata  = l0_rvalid ? mem_rdata : '0;
  assign l1_rdata  = l1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_dual_lane_arbiter.sv
// Directed bench for dmem_dual_lane_arbiter with a small
// synchronous memory model and a CNT_W=4 twin for saturation.
module tb_dmem_dual_lane_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        l0_req = 0, l0_we = 0, l1_req = 0, l1_we = 0;
  logic [31:0] l0_addr = 0, l0_wdata = 0, l1_addr = 0, l1_wdata = 0;
  logic        stall, mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic        l0_rvalid, l1_rvalid;
  logic [31:0] l0_rdata, l1_rdata;
  logic [15:0] conflict_cnt;

  logic        s_stall, s_en, s_we, s_v0, s_v1;
  logic [31:0] s_addr, s_wdata, s_d0, s_d1;
  logic [3:0]  cnt4;

  logic [31:0] mem [0:255];

  int nchk = 0;
  int npass = 0;
  int strobes;

  always #5 clk = ~clk;

  dmem_dual_lane_arbiter dut (
    .clk(clk), .reset(reset),
    .l0_req(l0_req), .l0_we(l0_we), .l0_addr(l0_addr), .l0_wdata(l0_wdata),
    .l1_req(l1_req), .l1_we(l1_we), .l1_addr(l1_addr), .l1_wdata(l1_wdata),
    .stall(stall), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .l0_rvalid(l0_rvalid), .l1_rvalid(l1_rvalid),
    .l0_rdata(l0_rdata), .l1_rdata(l1_rdata),
    .conflict_cnt(conflict_cnt)
  );

  dmem_dual_lane_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .l0_req(l0_req), .l0_we(l0_we), .l0_addr(l0_addr), .l0_wdata(l0_wdata),
    .l1_req(l1_req), .l1_we(l1_we), .l1_addr(l1_addr), .l1_wdata(l1_wdata),
    .stall(s_stall), .mem_en(s_en), .mem_we(s_we),
    .mem_addr(s_addr), .mem_wdata(s_wdata), .mem_rdata(mem_rdata),
    .l0_rvalid(s_v0), .l1_rvalid(s_v1),
    .l0_rdata(s_d0), .l1_rdata(s_d1),
    .conflict_cnt(cnt4)
  );

  // Single-ported synchronous memory driven by the main instance.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input logic r0, input logic w0,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1,
                      input logic [31:0] a1, input logic [31:0] d1);
    @(negedge clk);
    l0_req = r0; l0_we = w0; l0_addr = a0; l0_wdata = d0;
    l1_req = r1; l1_we = w1; l1_addr = a1; l1_wdata = d1;
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_cnt", {16'h0, conflict_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_en", {31'h0, mem_en}, 32'd0);
    chk("rst_stall", {31'h0, stall}, 32'd0);
    chk("rst_rv", {30'h0, l0_rvalid, l1_rvalid}, 32'd0);
    chk("rst_cnt0", {16'h0, conflict_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single lane load: preload by an uncontended store
    step(1, 1, 32'h10, 32'd7, 0, 0, 0, 0);
    chk("st_en", {30'h0, mem_en, mem_we}, 32'd3);
    step(1, 0, 32'h10, 0, 0, 0, 0, 0);
    chk("ld_en", {31'h0, mem_en}, 32'd1);
    chk("ld_stall", {31'h0, stall}, 32'd0);
    chk("ld_addr", mem_addr, 32'h10);
    idle();
    chk("ld_rv0", {31'h0, l0_rvalid}, 32'd1);
    chk("ld_rd0", l0_rdata, 32'd7);
    chk("ld_rv1", {31'h0, l1_rvalid}, 32'd0);
    chk("ld_rd1", l1_rdata, 32'd0);
    chk("ld_idle_en", {31'h0, mem_en}, 32'd0);

    // Conflict ordering: l0 store then l1 load, same address
    step(1, 1, 32'h20, 32'd5, 1, 0, 32'h20, 0);
    chk("co_stall_n", {31'h0, stall}, 32'd1);
    chk("co_we_n", {31'h0, mem_we}, 32'd1);
    chk("co_wd_n", mem_wdata, 32'd5);
    step(1, 1, 32'h20, 32'd5, 1, 0, 32'h20, 0);
    chk("co_stall_n1", {31'h0, stall}, 32'd0);
    chk("co_ld_n1", {30'h0, mem_en, mem_we}, 32'd2);
    chk("co_rv_n1", {30'h0, l0_rvalid, l1_rvalid}, 32'd0);
    idle();
    chk("co_rv_n2", {30'h0, l0_rvalid, l1_rvalid}, 32'd1);
    chk("co_rd1", l1_rdata, 32'd5);
    chk("co_rd0", l0_rdata, 32'd0);
    chk("co_cnt", {16'h0, conflict_cnt}, 32'd1);

    // Two stores to the same address
    step(1, 1, 32'h30, 32'd1, 1, 1, 32'h30, 32'd2);
    chk("ss_wd0", mem_wdata, 32'd1);
    step(1, 1, 32'h30, 32'd1, 1, 1, 32'h30, 32'd2);
    chk("ss_wd1", mem_wdata, 32'd2);
    idle();
    chk("ss_rv", {30'h0, l0_rvalid, l1_rvalid}, 32'd0);
    chk("ss_mem", mem[8'h30], 32'd2);
    chk("ss_cnt", {16'h0, conflict_cnt}, 32'd2);

    pulse_reset();

    // Back-to-back conflicts
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 32'h40 + 16 * i, 0, 1, 0, 32'h48 + 16 * i, 0);
      chk("bb_stall_a", {31'h0, stall}, 32'd1);
      chk("bb_addr_a", mem_addr, 32'h40 + 16 * i);
      if (i > 0) chk("bb_rv1", {30'h0, l0_rvalid, l1_rvalid}, 32'd1);
      strobes += int'(mem_en);
      step(1, 0, 32'h40 + 16 * i, 0, 1, 0, 32'h48 + 16 * i, 0);
      chk("bb_stall_b", {31'h0, stall}, 32'd0);
      chk("bb_addr_b", mem_addr, 32'h48 + 16 * i);
      chk("bb_rv0", {30'h0, l0_rvalid, l1_rvalid}, 32'd2);
      strobes += int'(mem_en);
    end
    idle();
    chk("bb_rv_last", {30'h0, l0_rvalid, l1_rvalid}, 32'd1);
    chk("bb_strobes", strobes, 32'd6);
    chk("bb_cnt", {16'h0, conflict_cnt}, 32'd3);

    // Reset asserted during HOLD
    step(1, 0, 32'h60, 0, 1, 0, 32'h64, 0);
    chk("rh_stall", {31'h0, stall}, 32'd1);
    @(negedge clk);
    #1;
    chk("rh_hold_en", {31'h0, mem_en}, 32'd1);
    chk("rh_hold_rv", {30'h0, l0_rvalid, l1_rvalid}, 32'd2);
    reset = 1'b0;
    #1;
    chk("rh_en", {31'h0, mem_en}, 32'd0);
    chk("rh_rv", {30'h0, l0_rvalid, l1_rvalid}, 32'd0);
    chk("rh_stall0", {31'h0, stall}, 32'd0);
    idle();
    reset = 1'b1;
    step(0, 0, 0, 0, 1, 0, 32'h50, 0);
    chk("rh_run_en", {31'h0, mem_en}, 32'd1);
    chk("rh_run_addr", mem_addr, 32'h50);
    chk("rh_run_stall", {31'h0, stall}, 32'd0);
    chk("rh_cnt", {16'h0, conflict_cnt}, 32'd0);

    // Saturation on the 4-bit twin
    repeat (20) begin
      step(1, 0, 32'h70, 0, 1, 0, 32'h74, 0);
      step(1, 0, 32'h70, 0, 1, 0, 32'h74, 0);
    end
    idle();
    chk("sat_cnt4", {28'h0, cnt4}, 32'd15);
    chk("sat_cnt16", {16'h0, conflict_cnt}, 32'd20);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
